// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver. The asynchronous serial line is synchronised, each frame
// is found by its start-bit falling edge, and every bit is sampled near its
// centre. Bit timing matches the companion transmitter: BIT_CYCLES clocks per
// bit (49 at the default clock and baud rate).
//
// Optional feature, selected by the macro UART_RX_FIFO_EN:
//   undefined : each good byte is presented on RxData with a one-clock
//               dataValid pulse; RxData holds until the next good byte.
//   defined   : good bytes are pushed into a 4-entry FIFO; dataValid means
//               "FIFO not empty", RxData shows the head entry and readAck pops.
//               A byte arriving while the FIFO is full (with no pop) is
//               dropped and the sticky overrun flag is set.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   RxD        in   serial input, idles high, asynchronous to clk
//   RxData     out  received byte, bit 0 is the first data bit on the line
//   dataValid  out  RxData valid (pulse, or FIFO-not-empty)
//   readAck    in   consumer pop (FIFO build only)
//   frameError out  one-clock pulse when a stop bit samples low
//   overrun    out  sticky overrun flag (FIFO build only, else 0)
//   isBusy     out  high from start-bit detection until back in IDLE
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_FREQ    = 6_250_000,
  parameter int BAUD_RATE   = 128000,
  parameter int BIT_CYCLES  = CLK_FREQ / BAUD_RATE + 1,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxData,
  output logic       dataValid,
  input  logic       readAck,
  output logic       frameError,
  output logic       overrun,
  output logic       isBusy
);

  localparam int CNT_W = $clog2(BIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  // Synchroniser and edge-detect history
  logic r_sync1;
  logic r_rxs;
  logic r_rxs_prev;

  // FSM and datapath registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shreg;
  logic             r_busy;
  logic             r_frame_error;

  // Next-state / strobe wires from the combinational FSM
  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       w_shreg_next;
  logic             w_good_byte;
  logic             w_frame_err;
  logic             w_fall;

  assign w_fall = r_rxs_prev & ~r_rxs;

  // Two-flop synchroniser on RxD plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= RxD;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
    end
  end

  // FSM state register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= CNT_ZERO;
      r_bit_idx     <= 3'd0;
      r_shreg       <= 8'h00;
      r_busy        <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_bit_idx     <= w_bit_idx_next;
      r_shreg       <= w_shreg_next;
      r_busy        <= (w_state_next != S_IDLE);
      r_frame_error <= w_frame_err;
    end
  end

  // Next-state logic: counting, mid-bit sampling and delivery strobes
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shreg_next   = r_shreg;
    w_good_byte    = 1'b0;
    w_frame_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == HALF_CNT) begin
          w_cnt_next = CNT_ZERO;
          // A line that is already high again at mid-start was a glitch
          if (!r_rxs) begin
            w_state_next   = S_DATA;
            w_bit_idx_next = 3'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST_CNT) begin
          w_shreg_next[r_bit_idx] = r_rxs;
          w_cnt_next              = CNT_ZERO;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_state_next = S_DATA;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_next = CNT_ZERO;
          // Returning to IDLE here lets a back-to-back start edge be caught
          if (r_rxs) begin
            w_good_byte  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must not look like a fresh start bit
        if (r_rxs) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT_HIGH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  assign isBusy     = r_busy;
  assign frameError = r_frame_error;

`ifdef UART_RX_FIFO_EN

  logic [7:0] r_fifo [0:3];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       r_overrun;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == 3'd0);
  assign w_full  = (r_count == 3'd4);
  assign w_pop   = readAck & ~w_empty;
  // When full, a simultaneous pop frees the slot the write lands in
  assign w_push  = w_good_byte & (~w_full | w_pop);

  // FIFO storage, wrapping pointers, occupancy and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= 8'h00;
      end
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_count   <= 3'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_shreg;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_good_byte && w_full && !w_pop) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign dataValid = ~w_empty;
  assign RxData    = r_fifo[r_rd_ptr];
  assign overrun   = r_overrun;

`else

  logic [7:0] r_rx_data;
  logic       r_data_valid;
  logic       w_unused_ack;

  assign w_unused_ack = readAck;

  // Output byte register and one-clock valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data    <= 8'h00;
      r_data_valid <= 1'b0;
    end else begin
      if (w_good_byte) begin
        r_rx_data <= r_shreg;
      end else begin
        r_rx_data <= r_rx_data;
      end
      r_data_valid <= w_good_byte;
    end
  end

  assign RxData    = r_rx_data;
  assign dataValid = r_data_valid;
  assign overrun   = 1'b0;

`endif

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver. Serial frames are driven at 49 clocks per
// bit; expected bytes are queued as frames are sent and popped by a monitor
// whenever the receiver presents a byte.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int BITC = 49;
  // 2 synchroniser clocks + 1 edge-detect clock + 25 start clocks + 8 data
  // bits + stop bit, each 49 clocks
  localparam int STOP_LATENCY = 3 + 25 + 9 * BITC;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] RxData;
  logic       dataValid;
  logic       readAck;
  logic       frameError;
  logic       overrun;
  logic       isBusy;

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .RxData     (RxData),
    .dataValid  (dataValid),
    .readAck    (readAck),
    .frameError (frameError),
    .overrun    (overrun),
    .isBusy     (isBusy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q [$];
  int n_valid        = 0;
  int n_ferr         = 0;
  int last_valid_cyc = 0;
  int last_ferr_cyc  = 0;
  bit busy_seen      = 1'b0;
  bit auto_ack       = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int start_cyc);
    RxD = 1'b0;
    start_cyc = cyc;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      tick(BITC);
    end
    RxD = stop_bit;
    tick(BITC);
  endtask

  // Monitor: scoreboard compare on every presented byte, event counting
  initial begin : monitor
    readAck = 1'b0;
    forever begin
      @(negedge clk);
      if (dataValid === 1'b1) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (auto_ack) begin
          check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("rx_byte", {24'h0, RxData}, {24'h0, exp_q.pop_front()});
          end
        end
      end
      if (frameError === 1'b1) begin
        n_ferr++;
        last_ferr_cyc = cyc;
      end
      if (isBusy === 1'b1) busy_seen = 1'b1;
      readAck = auto_ack && (dataValid === 1'b1);
    end
  end

  // Directed stimulus sequence
  initial begin : stim
    int st;
    RxD   = 1'b1;
    reset = 1'b1;
    tick(4);
    check("rst_dataValid",  32'(dataValid),  32'd0);
    check("rst_frameError", 32'(frameError), 32'd0);
    check("rst_isBusy",     32'(isBusy),     32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_RxData",     {24'h0, RxData}, 32'h0);
    reset = 1'b0;
    tick(2);

    // Idle line
    n_valid = 0; n_ferr = 0; busy_seen = 1'b0;
    tick(1000);
    check("idle_valid", 32'(n_valid),   32'd0);
    check("idle_ferr",  32'(n_ferr),    32'd0);
    check("idle_busy",  32'(busy_seen), 32'd0);

    // Single byte and its latency from the start-bit edge
    n_valid = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, st);
    tick(30);
    check("single_count",   32'(n_valid),            32'd1);
    check("single_q_empty", 32'(exp_q.size()),       32'd0);
    check("single_latency", 32'(last_valid_cyc - st), 32'(STOP_LATENCY));
    check("single_busy",    32'(isBusy),             32'd0);
`ifndef UART_RX_FIFO_EN
    check("single_hold",    {24'h0, RxData},         32'hA5);
`endif

    // Back-to-back frames, no idle gap
    n_valid = 0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, st);
    send_frame(8'hFF, 1'b1, st);
    tick(30);
    check("b2b_count",   32'(n_valid),      32'd2);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // Start-bit glitch: rejected at the mid-start sample
    n_valid = 0; n_ferr = 0;
    RxD = 1'b0;
    tick(10);
    RxD = 1'b1;
    check("glitch_busy_early", 32'(isBusy), 32'd1);
    tick(17);
    check("glitch_busy_last",  32'(isBusy), 32'd1);
    tick(1);
    check("glitch_busy_clear", 32'(isBusy), 32'd0);
    tick(60);
    check("glitch_valid", 32'(n_valid), 32'd0);
    check("glitch_ferr",  32'(n_ferr),  32'd0);

    // Frame error followed by a held-low line, then a clean byte
    n_valid = 0; n_ferr = 0;
    send_frame(8'h3C, 1'b0, st);
    tick(200);
    check("ferr_count",   32'(n_ferr),               32'd1);
    check("ferr_timing",  32'(last_ferr_cyc - st),   32'(STOP_LATENCY));
    check("ferr_valid",   32'(n_valid),              32'd0);
    check("ferr_waiting", 32'(isBusy),               32'd1);
    RxD = 1'b1;
    tick(4);
    check("ferr_release", 32'(isBusy), 32'd0);
    tick(20);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, st);
    tick(30);
    check("after_ferr_count",   32'(n_valid),      32'd1);
    check("after_ferr_q_empty", 32'(exp_q.size()), 32'd0);
    check("after_ferr_ferr",    32'(n_ferr),       32'd1);

    // Reset asserted during bit 4 of 0x5A
    n_valid = 0;
    RxD = 1'b0;
    tick(BITC);
    for (int i = 0; i < 4; i++) begin
      RxD = ((8'h5A >> i) & 8'h01) != 8'h00;
      tick(BITC);
    end
    RxD = 1'b1;
    tick(20);
    check("midrst_busy_before", 32'(isBusy), 32'd1);
    reset = 1'b1;
    tick(1);
    check("midrst_dataValid",  32'(dataValid),  32'd0);
    check("midrst_frameError", 32'(frameError), 32'd0);
    check("midrst_isBusy",     32'(isBusy),     32'd0);
    check("midrst_overrun",    32'(overrun),    32'd0);
    check("midrst_RxData",     {24'h0, RxData}, 32'h0);
    reset = 1'b0;
    tick(600);
    check("midrst_no_byte", 32'(n_valid), 32'd0);
    check("midrst_idle",    32'(isBusy),  32'd0);

`ifdef UART_RX_FIFO_EN
    // Five bytes with no reads: four are kept, the fifth overruns
    auto_ack = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, st);
    end
    tick(30);
    check("fifo_overrun",   32'(overrun),    32'd1);
    check("fifo_valid",     32'(dataValid),  32'd1);
    check("fifo_head",      {24'h0, RxData}, 32'h01);
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
    end
    n_valid  = 0;
    auto_ack = 1'b1;
    tick(20);
    check("fifo_read_count", 32'(n_valid),      32'd4);
    check("fifo_q_empty",    32'(exp_q.size()), 32'd0);
    check("fifo_drained",    32'(dataValid),    32'd0);
    check("fifo_sticky",     32'(overrun),      32'd1);
`else
    check("no_overrun", 32'(overrun), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's UART transmitter.
- Takes the asynchronous serial line, recovers bytes by mid-bit sampling, and presents each byte with a valid strobe to the DNN accelerator host interface.
- Bit timing matches the transmitter exactly: each bit period is CLK_FREQ/BAUD_RATE + 1 clocks, which is 49 clocks at the defaults.

Parameters:
- CLK_FREQ, 6_250_000, system clock frequency in Hz.
- BAUD_RATE, 128000, line rate in bit/s.
- BIT_CYCLES, CLK_FREQ/BAUD_RATE + 1 (= 49), clocks per bit.
- HALF_CYCLES, BIT_CYCLES/2 (= 24), clocks from the start-bit falling edge to the start-bit sample point.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- RxD  in  1  serial input; idles high; asynchronous to clk.
- RxData  out  8  received byte, LSB = first data bit.
- dataValid  out  1  RxData valid (meaning depends on UART_RX_FIFO_EN, see below).
- readAck  in  1  consumer pop; used only with UART_RX_FIFO_EN, ignored otherwise.
- frameError  out  1  one-cycle pulse when the stop bit samples 0.
- overrun  out  1  sticky overrun flag; used only with UART_RX_FIFO_EN, constant 0 otherwise.
- isBusy  out  1  high from start-bit detection until the return to IDLE.

Behaviour:
- Reset values: RxData=0, dataValid=0, frameError=0, overrun=0, isBusy=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame aborts the frame with no output.
- RxD passes through a 2-flop synchronizer (rxs). Edge detection uses rxs and its previous value, so the input latency is 2 clocks.
- IDLE:
  - On an rxs falling edge (prev=1, cur=0): go to START, cnt=0, isBusy=1.
- START:
  - cnt increments each clock.
  - At cnt==HALF_CYCLES, sample rxs. If 0: go to DATA, cnt=0, bitIdx=0. If 1 (glitch): go to IDLE, isBusy=0, no outputs.
- DATA:
  - cnt increments each clock.
  - At cnt==BIT_CYCLES-1: shift the rxs sample into shreg[bitIdx], cnt=0, bitIdx++.
  - After bitIdx 7 is sampled, go to STOP.
- STOP:
  - At cnt==BIT_CYCLES-1, sample rxs.
  - If 1: deliver shreg (see below), go to IDLE, isBusy=0.
  - If 0: frameError=1 for exactly 1 clock, byte discarded, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxs==1, then go to IDLE and set isBusy=0.
  - This prevents a stuck-low line (break) from retriggering.
- Frame timing: sample points fall at the middle of each bit. Delivery occurs 1 clock after the stop sample.
- Back-to-back frames: a start edge arriving immediately after the stop sample must be caught, because IDLE is entered in the same cycle the byte is delivered.
- Width rules: cnt is $clog2(BIT_CYCLES)+1 bits. bitIdx is 3 bits. No wrap: cnt clears at every sample point.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Undefined (default):
  - On good stop, RxData<=shreg and dataValid=1 for exactly 1 clock.
  - RxData holds its value until the next good byte.
  - readAck is ignored; overrun=0.
- Defined:
  - 4-entry FIFO with 2-bit pointers that wrap, plus a 3-bit count.
  - Good byte: push.
  - dataValid = !empty; RxData = head entry, combinationally from the FIFO.
  - readAck with !empty: pop. readAck when empty: no effect.
  - Push and pop in the same cycle: count unchanged, both pointers advance (allowed even when full).
  - Push when full with no pop: byte dropped, overrun<=1. overrun stays set until reset.

Test Plan:
- Idle line: reset, then hold RxD=1 for 1000 clocks -> dataValid, frameError and isBusy stay 0.
- Single byte: send 0xA5 at 49 clocks/bit -> exactly one dataValid with RxData=0xA5, arriving 1 clock after the stop sample; isBusy=0 afterwards.
- Back-to-back 0x00 then 0xFF with no idle gap (sourced from the team transmitter) -> two dataValid pulses with 0x00 then 0xFF.
- Glitch: drive RxD low for 10 clocks then high -> return to IDLE at the HALF_CYCLES sample, no dataValid, no frameError.
- Frame error: send 0x3C with stop bit=0, then hold low 200 clocks -> one frameError pulse, no dataValid, and no retrigger until RxD goes high. A following 0x11 is then received correctly.
- Reset mid-frame (reset asserted during bit 4 of 0x5A) -> all outputs 0 next clock, no byte delivered. FIFO build additionally: send 5 bytes 0x01..0x05 without readAck -> 0x01..0x04 read back in order and overrun=1.
